// File: rtl/csr_machine_unit_if.sv
// rtl/csr_machine_unit_if.sv - CSR access bus between the execute stage and the M-mode CSR unit
interface csr_machine_unit_if #(
    parameter int XLEN = 32
);
    logic            csr_valid;
    logic [1:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_wr_suppress;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;

    modport master (
        output csr_valid, csr_op, csr_addr, csr_wdata, csr_wr_suppress,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_wdata, csr_wr_suppress,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_machine_unit.sv
// rtl/csr_machine_unit.sv - M-mode CSR file with counters, trap entry, mret and PC redirect
module csr_machine_unit #(
    parameter int          XLEN        = 32,
    parameter logic [63:0] HART_ID     = 64'h0,
    parameter logic [63:0] MTVEC_RESET = 64'h0,
    parameter bit          VECTORED_EN = 1'b1,
    parameter logic [63:0] MISA_VALUE  = 64'h4000_0100
) (
    input  logic                clk,
    input  logic                rst,
    csr_machine_unit_if.slave   csr,
    input  logic                trap_valid,
    input  logic [XLEN-1:0]     trap_cause,
    input  logic [XLEN-1:0]     trap_pc,
    input  logic [XLEN-1:0]     trap_tval,
    input  logic                mret_valid,
    input  logic                instret_inc,
    input  logic                irq_mtip,
    input  logic                irq_msip,
    input  logic                irq_meip,
    output logic                irq_pending,
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc
);
    localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304,
                            A_MTVEC = 12'h305, A_MSCRATCH = 12'h340, A_MEPC = 12'h341,
                            A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344,
                            A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02,
                            A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82;

    logic              mst_mie, mst_mpie;
    logic [2:0]        mie_bits, mip_bits;
    logic [XLEN-1:2]   mtvec_base;
    logic [1:0]        mtvec_mode;
    logic [XLEN-1:0]   mscratch, mepc, mcause, mtval;
    logic [63:0]       mcycle, minstret;

    logic              implemented, access, does_write, csr_we, mode_ok;
    logic [XLEN-1:0]   cur_val, wval, mtvec_base_addr;

    always_comb begin
        implemented = 1'b1;
        cur_val     = '0;
        unique case (csr.csr_addr)
            12'hF11, 12'hF12, 12'hF13, 12'hF15: cur_val = '0;
            12'hF14:    cur_val = HART_ID[XLEN-1:0];
            A_MSTATUS: begin
                cur_val[12:11] = 2'b11;
                cur_val[7]     = mst_mpie;
                cur_val[3]     = mst_mie;
            end
            A_MISA:     cur_val = MISA_VALUE[XLEN-1:0];
            A_MIE: begin
                cur_val[11] = mie_bits[2];
                cur_val[7]  = mie_bits[1];
                cur_val[3]  = mie_bits[0];
            end
            A_MTVEC:    cur_val = {mtvec_base, mtvec_mode};
            A_MSCRATCH: cur_val = mscratch;
            A_MEPC:     cur_val = mepc;
            A_MCAUSE:   cur_val = mcause;
            A_MTVAL:    cur_val = mtval;
            A_MIP: begin
                cur_val[11] = mip_bits[2];
                cur_val[7]  = mip_bits[1];
                cur_val[3]  = mip_bits[0];
            end
            A_MCYCLE:   cur_val = XLEN'(mcycle);
            A_MINSTRET: cur_val = XLEN'(minstret);
            A_MCYCLEH:   if (XLEN == 32) cur_val = XLEN'(mcycle >> 32);   else implemented = 1'b0;
            A_MINSTRETH: if (XLEN == 32) cur_val = XLEN'(minstret >> 32); else implemented = 1'b0;
            default:    implemented = 1'b0;
        endcase
    end

    always_comb begin
        access     = csr.csr_valid && (csr.csr_op != 2'b00);
        does_write = (csr.csr_op == 2'b01) || !csr.csr_wr_suppress;
        csr.csr_illegal = access && (!implemented || ((csr.csr_addr[11:10] == 2'b11) && does_write));
        csr.csr_rdata   = access ? cur_val : '0;
        unique case (csr.csr_op)
            2'b01:   wval = csr.csr_wdata;
            2'b10:   wval = cur_val | csr.csr_wdata;
            2'b11:   wval = cur_val & ~csr.csr_wdata;
            default: wval = cur_val;
        endcase
        // Trap and mret own the cycle; a colliding CSR write is dropped.
        csr_we  = access && does_write && !csr.csr_illegal && !trap_valid && !mret_valid;
        mode_ok = (wval[1:0] == 2'b00) || ((wval[1:0] == 2'b01) && VECTORED_EN);
    end

    always_comb begin
        mtvec_base_addr = {mtvec_base, 2'b00};
        redirect_valid  = trap_valid || mret_valid;
        redirect_pc     = '0;
        if (trap_valid) begin
            if ((mtvec_mode == 2'b01) && trap_cause[XLEN-1])
                redirect_pc = mtvec_base_addr + (XLEN'(trap_cause[XLEN-2:0]) << 2);
            else
                redirect_pc = mtvec_base_addr;
        end else if (mret_valid) begin
            redirect_pc = mepc;
        end
        irq_pending = mst_mie && |(mie_bits & mip_bits);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mst_mie    <= 1'b0;
            mst_mpie   <= 1'b0;
            mie_bits   <= '0;
            mip_bits   <= '0;
            mtvec_base <= MTVEC_RESET[XLEN-1:2];
            mtvec_mode <= VECTORED_EN ? MTVEC_RESET[1:0] : 2'b00;
            mscratch   <= '0;
            mepc       <= '0;
            mcause     <= '0;
            mtval      <= '0;
            mcycle     <= '0;
            minstret   <= '0;
        end else begin
            mip_bits <= {irq_meip, irq_mtip, irq_msip};
            if (trap_valid) begin
                mepc     <= {trap_pc[XLEN-1:2], 2'b00};
                mcause   <= trap_cause;
                mtval    <= trap_tval;
                mst_mpie <= mst_mie;
                mst_mie  <= 1'b0;
            end else if (mret_valid) begin
                mst_mie  <= mst_mpie;
                mst_mpie <= 1'b1;
            end else if (csr_we) begin
                case (csr.csr_addr)
                    A_MSTATUS: begin
                        mst_mie  <= wval[3];
                        mst_mpie <= wval[7];
                    end
                    A_MIE: mie_bits <= {wval[11], wval[7], wval[3]};
                    A_MTVEC: begin
                        mtvec_base <= wval[XLEN-1:2];
                        if (mode_ok) mtvec_mode <= wval[1:0];
                    end
                    A_MSCRATCH: mscratch <= wval;
                    A_MEPC:     mepc     <= {wval[XLEN-1:2], 2'b00};
                    A_MCAUSE:   mcause   <= wval;
                    A_MTVAL:    mtval    <= wval;
                    default: ;
                endcase
            end
            // A half written this cycle freezes the whole counter: no increment, no carry.
            if (csr_we && csr.csr_addr == A_MCYCLE)
                mcycle <= (XLEN == 32) ? {mcycle[63:32], 32'(wval)} : 64'(wval);
            else if (csr_we && csr.csr_addr == A_MCYCLEH)
                mcycle <= {32'(wval), mcycle[31:0]};
            else
                mcycle <= mcycle + 64'd1;
            if (csr_we && csr.csr_addr == A_MINSTRET)
                minstret <= (XLEN == 32) ? {minstret[63:32], 32'(wval)} : 64'(wval);
            else if (csr_we && csr.csr_addr == A_MINSTRETH)
                minstret <= {32'(wval), minstret[31:0]};
            else
                minstret <= minstret + 64'(instret_inc);
        end
    end
endmodule

// File: tb/tb_csr_machine_unit.sv
// tb/tb_csr_machine_unit.sv - self-checking bench for csr_machine_unit with a reference CSR model
module tb_csr_machine_unit;
    localparam int          XLEN = 32;
    localparam logic [63:0] HART = 64'd3;
    localparam logic [63:0] MTVR = 64'h201;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_machine_unit_if #(.XLEN(XLEN)) bus ();
    logic trap_valid, mret_valid, instret_inc, irq_mtip, irq_msip, irq_meip;
    logic [31:0] trap_cause, trap_pc, trap_tval, redirect_pc;
    logic irq_pending, redirect_valid;

    csr_machine_unit #(.XLEN(XLEN), .HART_ID(HART), .MTVEC_RESET(MTVR), .VECTORED_EN(1'b1),
                       .MISA_VALUE(64'h4000_0100)) dut (
        .clk(clk), .rst(rst), .csr(bus.slave),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
        .mret_valid(mret_valid), .instret_inc(instret_inc),
        .irq_mtip(irq_mtip), .irq_msip(irq_msip), .irq_meip(irq_meip),
        .irq_pending(irq_pending), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    int tests_run = 0;
    int fails = 0;

    // Reference model state
    logic        m_mie, m_mpie;
    logic [31:0] m_mie_r, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return {19'b0, 2'b11, 3'b0, m_mpie, 3'b0, m_mie, 3'b0};
            12'h301: return 32'h4000_0100;
            12'h304: return m_mie_r;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hF14: return 32'(HART);
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset;
        m_mie = 0; m_mpie = 0; m_mie_r = 0; m_mtvec = 32'(MTVR);
        m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    endtask

    task automatic clear_inputs;
        bus.csr_valid = 0; bus.csr_op = 0; bus.csr_addr = 0; bus.csr_wdata = 0; bus.csr_wr_suppress = 0;
        trap_valid = 0; trap_cause = 0; trap_pc = 0; trap_tval = 0; mret_valid = 0;
    endtask

    // Drives one CSR access for one cycle, captures the combinational response mid-cycle.
    task automatic access(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                          input logic sup, output logic [31:0] rd, output logic ill);
        bus.csr_valid = 1; bus.csr_op = op; bus.csr_addr = addr; bus.csr_wdata = wd; bus.csr_wr_suppress = sup;
        #2;
        rd = bus.csr_rdata; ill = bus.csr_illegal;
        @(posedge clk); #1;
        bus.csr_valid = 0; bus.csr_op = 0;
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic ill;
        rst = 1; clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        tests_run++;
        if (bus.csr_rdata !== 0 || bus.csr_illegal !== 0 || irq_pending !== 0 || redirect_valid !== 0 || redirect_pc !== 0) begin
            fails++;
            $display("FAIL reset_outputs: got rdata=%h ill=%b irq=%b rv=%b rpc=%h, expected all 0",
                     bus.csr_rdata, bus.csr_illegal, irq_pending, redirect_valid, redirect_pc);
        end
        repeat (10) @(posedge clk);
        #1;
        access(2'b10, 12'hB00, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'd10) begin fails++; $display("FAIL mcycle_after_10: got %0d expected 10", rd); end
        access(2'b10, 12'h300, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h1800) begin fails++; $display("FAIL reset_mstatus: got %h expected 00001800", rd); end
        access(2'b10, 12'hF14, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'(HART) || ill !== 0) begin fails++; $display("FAIL mhartid: got %h ill=%b expected %h ill=0", rd, ill, 32'(HART)); end
        access(2'b10, 12'h305, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'(MTVR)) begin fails++; $display("FAIL reset_mtvec: got %h expected %h", rd, 32'(MTVR)); end
    endtask

    task automatic test_rmw;
        logic [31:0] rd; logic ill;
        access(2'b01, 12'h340, 32'hA5A5A5A5, 0, rd, ill);
        tests_run++; if (rd !== 32'h0) begin fails++; $display("FAIL rmw_rw: got %h expected 00000000", rd); end
        access(2'b10, 12'h340, 32'h0F, 0, rd, ill);
        tests_run++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL rmw_rs: got %h expected a5a5a5a5", rd); end
        access(2'b11, 12'h340, 32'hA0, 0, rd, ill);
        tests_run++; if (rd !== 32'hA5A5A5AF) begin fails++; $display("FAIL rmw_rc: got %h expected a5a5a5af", rd); end
        access(2'b10, 12'h340, 32'hFFFF, 1, rd, ill);
        tests_run++; if (rd !== 32'hA5A5A50F) begin fails++; $display("FAIL rmw_final: got %h expected a5a5a50f", rd); end
        access(2'b01, 12'h341, 32'h0000_1237, 0, rd, ill);
        access(2'b10, 12'h341, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h0000_1234) begin fails++; $display("FAIL mepc_align: got %h expected 00001234", rd); end
    endtask

    task automatic test_illegal;
        logic [31:0] rd; logic ill;
        access(2'b01, 12'hF11, 32'hFFFF_FFFF, 0, rd, ill);
        tests_run++; if (ill !== 1) begin fails++; $display("FAIL ill_write_ro: got %b expected 1", ill); end
        access(2'b10, 12'h7C0, 32'h1, 0, rd, ill);
        tests_run++; if (ill !== 1 || rd !== 0) begin fails++; $display("FAIL ill_unimpl: got ill=%b rd=%h expected 1/0", ill, rd); end
        access(2'b10, 12'hB80, 32'h1, 1, rd, ill);
        tests_run++; if (ill !== 0) begin fails++; $display("FAIL rs_suppressed_b80: got %b expected 0", ill); end
        access(2'b10, 12'hF11, 0, 1, rd, ill);
        tests_run++; if (rd !== 0 || ill !== 0) begin fails++; $display("FAIL f11_unchanged: got %h ill=%b expected 0/0", rd, ill); end
        access(2'b01, 12'h301, 32'h0, 0, rd, ill);
        access(2'b10, 12'h301, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h4000_0100 || ill !== 0) begin fails++; $display("FAIL misa_ro: got %h ill=%b expected 40000100/0", rd, ill); end
        access(2'b10, 12'h340, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'hA5A5A50F) begin fails++; $display("FAIL ill_no_effect: got %h expected a5a5a50f", rd); end
    endtask

    task automatic test_trap_mret;
        logic [31:0] rd; logic ill;
        access(2'b01, 12'h305, 32'h101, 0, rd, ill);
        access(2'b10, 12'h300, 32'h8, 0, rd, ill);
        trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1236; trap_tval = 32'hDEAD;
        #2;
        tests_run++; if (redirect_valid !== 1 || redirect_pc !== 32'h11C) begin fails++; $display("FAIL trap_redirect: got rv=%b pc=%h expected 1/0000011c", redirect_valid, redirect_pc); end
        @(posedge clk); #1;
        trap_valid = 0;
        access(2'b10, 12'h341, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h1234) begin fails++; $display("FAIL trap_mepc: got %h expected 00001234", rd); end
        access(2'b10, 12'h300, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h1880) begin fails++; $display("FAIL trap_mstatus: got %h expected 00001880", rd); end
        access(2'b10, 12'h343, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'hDEAD) begin fails++; $display("FAIL trap_mtval: got %h expected 0000dead", rd); end
        mret_valid = 1;
        #2;
        tests_run++; if (redirect_valid !== 1 || redirect_pc !== 32'h1234) begin fails++; $display("FAIL mret_redirect: got rv=%b pc=%h expected 1/00001234", redirect_valid, redirect_pc); end
        @(posedge clk); #1;
        mret_valid = 0;
        access(2'b10, 12'h300, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h1888) begin fails++; $display("FAIL mret_mstatus: got %h expected 00001888", rd); end
        access(2'b01, 12'h305, 32'h302, 0, rd, ill);
        access(2'b10, 12'h305, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h301) begin fails++; $display("FAIL mtvec_mode_keep: got %h expected 00000301", rd); end
    endtask

    task automatic test_counters;
        logic [31:0] rd; logic ill;
        access(2'b01, 12'hB00, 32'hFFFF_FFFF, 0, rd, ill);
        access(2'b01, 12'hB80, 32'hFFFF_FFFF, 0, rd, ill);
        access(2'b10, 12'hB00, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mcycle_written: got %h expected ffffffff", rd); end
        access(2'b10, 12'hB00, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h0) begin fails++; $display("FAIL mcycle_wrap_lo: got %h expected 00000000", rd); end
        access(2'b10, 12'hB80, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h0) begin fails++; $display("FAIL mcycle_wrap_hi: got %h expected 00000000", rd); end
        access(2'b10, 12'hB02, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h0) begin fails++; $display("FAIL minstret_idle: got %0d expected 0", rd); end
        instret_inc = 1;
        repeat (5) @(posedge clk);
        #1 instret_inc = 0;
        access(2'b10, 12'hB02, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'd5) begin fails++; $display("FAIL minstret_5: got %0d expected 5", rd); end
        instret_inc = 1;
        access(2'b01, 12'hB02, 32'd100, 0, rd, ill);
        instret_inc = 0;
        access(2'b10, 12'hB02, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'd100) begin fails++; $display("FAIL minstret_write_wins: got %0d expected 100", rd); end
    endtask

    task automatic test_irq_priority;
        logic [31:0] rd; logic ill;
        access(2'b01, 12'h304, 32'h80, 0, rd, ill);
        irq_mtip = 1;
        #2;
        tests_run++; if (irq_pending !== 0) begin fails++; $display("FAIL irq_not_yet: got %b expected 0", irq_pending); end
        @(posedge clk); #1;
        tests_run++; if (irq_pending !== 1) begin fails++; $display("FAIL irq_rise: got %b expected 1", irq_pending); end
        trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h4000; trap_tval = 0;
        access(2'b01, 12'h340, 32'h1234_5678, 0, rd, ill);
        trap_valid = 0;
        tests_run++; if (rd !== 32'hA5A5A50F) begin fails++; $display("FAIL collide_read_old: got %h expected a5a5a50f", rd); end
        access(2'b10, 12'h340, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'hA5A5A50F) begin fails++; $display("FAIL collide_write_dropped: got %h expected a5a5a50f", rd); end
        access(2'b10, 12'h341, 0, 1, rd, ill);
        tests_run++; if (rd !== 32'h4000 || irq_pending !== 0) begin fails++; $display("FAIL collide_trap_state: got mepc=%h irq=%b expected 00004000/0", rd, irq_pending); end
        irq_mtip = 0;
    endtask

    task automatic test_reset_midway;
        logic [31:0] rd; logic ill;
        rst = 1;
        bus.csr_valid = 1; bus.csr_op = 2'b01; bus.csr_addr = 12'h340; bus.csr_wdata = 32'h5555;
        trap_valid = 1; trap_pc = 32'h8888;
        @(posedge clk); #1;
        rst = 0; clear_inputs();
        access(2'b10, 12'h340, 0, 1, rd, ill);
        tests_run++; if (rd !== 0) begin fails++; $display("FAIL midreset_mscratch: got %h expected 0", rd); end
        access(2'b10, 12'h341, 0, 1, rd, ill);
        tests_run++; if (rd !== 0) begin fails++; $display("FAIL midreset_mepc: got %h expected 0", rd); end
        model_reset();
    endtask

    task automatic test_random;
        logic [11:0] addrs [10] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340,
                                    12'h341, 12'h342, 12'h343, 12'h344, 12'hF14};
        logic [11:0] a; logic [1:0] op; logic [31:0] wd, cause, pc, tval, exp_rd, exp_pc, old, nv;
        logic sup, tv, mv, acc, wr, exp_ill;
        int r;
        for (int i = 0; i < 300; i++) begin
            a = addrs[$urandom_range(0, 9)]; op = 2'($urandom_range(0, 3)); wd = $urandom;
            sup = 1'($urandom_range(0, 1)); r = $urandom_range(0, 7);
            tv = (r == 0); mv = (r == 1);
            cause = ($urandom_range(0, 1) != 0) ? (32'h8000_0000 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 15));
            pc = $urandom; tval = $urandom;
            acc = (op != 0); wr = (op == 2'b01) || !sup;
            exp_ill = acc && (a == 12'hF14) && wr;
            old = model_read(a);
            exp_rd = acc ? old : 32'h0;
            if (tv) exp_pc = (m_mtvec[1:0] == 2'b01 && cause[31]) ? (m_mtvec & ~32'h3) + ({1'b0, cause[30:0]} << 2) : (m_mtvec & ~32'h3);
            else if (mv) exp_pc = m_mepc;
            else exp_pc = 0;

            bus.csr_valid = (op != 0) || (r == 2); bus.csr_op = op; bus.csr_addr = a; bus.csr_wdata = wd; bus.csr_wr_suppress = sup;
            trap_valid = tv; trap_cause = cause; trap_pc = pc; trap_tval = tval; mret_valid = mv;
            #2;
            tests_run++;
            if (bus.csr_rdata !== exp_rd || bus.csr_illegal !== exp_ill || redirect_valid !== (tv | mv) || redirect_pc !== exp_pc) begin
                fails++;
                $display("FAIL random[%0d] a=%h op=%0d: got rd=%h ill=%b rv=%b pc=%h expected rd=%h ill=%b rv=%b pc=%h",
                         i, a, op, bus.csr_rdata, bus.csr_illegal, redirect_valid, redirect_pc, exp_rd, exp_ill, tv | mv, exp_pc);
            end
            @(posedge clk); #1;
            clear_inputs();

            if (tv) begin
                m_mepc = pc & ~32'h3; m_mcause = cause; m_mtval = tval; m_mpie = m_mie; m_mie = 0;
            end else if (mv) begin
                m_mie = m_mpie; m_mpie = 1;
            end else if (acc && wr && !exp_ill) begin
                nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
                case (a)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h304: m_mie_r = nv & 32'h888;
                    12'h305: m_mtvec = (nv[1:0] <= 2'b01) ? nv : ((nv & ~32'h3) | (m_mtvec & 32'h3));
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~32'h3;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    default: ;
                endcase
            end
        end
    endtask

    initial begin
        rst = 1; instret_inc = 0; irq_mtip = 0; irq_msip = 0; irq_meip = 0;
        clear_inputs();
        test_reset();
        test_rmw();
        test_illegal();
        test_trap_mret();
        test_counters();
        test_irq_priority();
        test_reset_midway();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
